// File: rtl/cache_ctrl_if.sv
// Handshake bundle between the MEM-stage pipeline/memory side (master) and the
// data-cache controller (slave).
interface cache_ctrl_if #(
  parameter int BEAT_W = 2,
  parameter int CNT_W  = 16
);
  logic [5:0]        opcode;
  logic              hit;
  logic              dirty;
  logic              mem_ack;
  logic              stall;
  logic              reg_write_enable;
  logic              cache_we;
  logic              cache_in_select;
  logic              mem_req;
  logic              mem_we;
  logic              mem_in_select;
  logic [1:0]        size;
  logic [BEAT_W-1:0] beat_idx;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;

  modport master (
    output opcode, hit, dirty, mem_ack,
    input  stall, reg_write_enable, cache_we, cache_in_select,
           mem_req, mem_we, mem_in_select, size, beat_idx,
           hit_count, miss_count
  );

  modport slave (
    input  opcode, hit, dirty, mem_ack,
    output stall, reg_write_enable, cache_we, cache_in_select,
           mem_req, mem_we, mem_in_select, size, beat_idx,
           hit_count, miss_count
  );
endinterface

// File: rtl/cache_ctrl_fsm.sv
// Data-cache controller: zero-latency hits, multi-beat write-back and line fill
// over a req/ack memory handshake, saturating hit/miss statistics.
module cache_ctrl_fsm #(
  parameter int LINE_WORDS = 4,
  parameter int BEAT_W     = 2,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst_b,
  cache_ctrl_if.slave bus
);
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_LH = 6'b100001;
  localparam logic [5:0] OP_LB = 6'b100000;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WB = 2'd1, FILL = 2'd2} state_t;

  state_t            state;
  logic [BEAT_W-1:0] beat_idx;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;
  logic              is_load;
  logic              is_store;
  logic              is_mem;
  logic              last_beat;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    bus.size = 2'b00;
    case (bus.opcode)
      OP_LW: begin is_load  = 1'b1; bus.size = 2'b00; end
      OP_LH: begin is_load  = 1'b1; bus.size = 2'b01; end
      OP_LB: begin is_load  = 1'b1; bus.size = 2'b10; end
      OP_SW: begin is_store = 1'b1; bus.size = 2'b00; end
      OP_SH: begin is_store = 1'b1; bus.size = 2'b01; end
      OP_SB: begin is_store = 1'b1; bus.size = 2'b10; end
      default: ;
    endcase
  end

  assign is_mem    = is_load | is_store;
  assign last_beat = (beat_idx == LAST_BEAT);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= IDLE;
      beat_idx   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mem) begin
            if (bus.hit) begin
              hit_count <= sat_inc(hit_count);
            end else begin
              miss_count <= sat_inc(miss_count);
              beat_idx   <= '0;
              state      <= bus.dirty ? WB : FILL;
            end
          end
        end
        WB: begin
          if (bus.mem_ack) begin
            if (last_beat) begin
              beat_idx <= '0;
              state    <= FILL;
            end else begin
              beat_idx <= beat_idx + BEAT_W'(1);
            end
          end
        end
        FILL: begin
          if (bus.mem_ack) begin
            if (last_beat) begin
              beat_idx <= '0;
              state    <= IDLE;
            end else begin
              beat_idx <= beat_idx + BEAT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Select outputs follow the current state and inputs; all forced low in reset.
  always_comb begin
    bus.stall            = 1'b0;
    bus.reg_write_enable = 1'b0;
    bus.cache_we         = 1'b0;
    bus.cache_in_select  = 1'b0;
    bus.mem_req          = 1'b0;
    bus.mem_we           = 1'b0;
    bus.mem_in_select    = 1'b0;
    if (rst_b) begin
      case (state)
        IDLE: begin
          if (is_mem) begin
            if (bus.hit) begin
              bus.reg_write_enable = is_load;
              bus.cache_we         = is_store;
              bus.cache_in_select  = is_store;
            end else begin
              bus.stall = 1'b1;
            end
          end
        end
        WB: begin
          bus.stall         = 1'b1;
          bus.mem_req       = 1'b1;
          bus.mem_we        = 1'b1;
          bus.mem_in_select = 1'b1;
        end
        FILL: begin
          bus.stall    = 1'b1;
          bus.mem_req  = 1'b1;
          bus.cache_we = bus.mem_ack;
        end
        default: ;
      endcase
    end
  end

  assign bus.beat_idx   = beat_idx;
  assign bus.hit_count  = hit_count;
  assign bus.miss_count = miss_count;
endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Bench for cache_ctrl_fsm: a 4-word/16-bit-counter instance and a 1-word/2-bit-counter
// instance share stimulus; a beats-remaining model checks both every cycle.
module tb_cache_ctrl_fsm;
  localparam logic [5:0] LW = 6'b100011, LH = 6'b100001, LB = 6'b100000;
  localparam logic [5:0] SW = 6'b101011, SH = 6'b101001, SB = 6'b101000;
  localparam logic [5:0] NOP = 6'b000000;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  cache_ctrl_if #(.BEAT_W(2), .CNT_W(16)) if0 ();
  cache_ctrl_if #(.BEAT_W(1), .CNT_W(2))  if1 ();

  cache_ctrl_fsm #(.LINE_WORDS(4), .BEAT_W(2), .CNT_W(16)) dut0 (
    .clk(clk), .rst_b(rst_b), .bus(if0));
  cache_ctrl_fsm #(.LINE_WORDS(1), .BEAT_W(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_b(rst_b), .bus(if1));

  int checks = 0;
  int failures = 0;

  logic [5:0] cur_op;
  logic       cur_hit, cur_dirty, cur_ack;

  // Model: a pending miss is just a count of write-back and fill beats left.
  int lw[2]   = '{4, 1};
  int cmax[2] = '{65535, 3};
  int wb_left[2], fill_left[2], hc[2], mc[2];

  typedef struct {
    logic [6:0] flags;  // {stall, rwe, cache_we, cache_in_sel, mem_req, mem_we, mem_in_sel}
    int sz;
    int beat;
    int hcnt;
    int mcnt;
  } obs_t;

  typedef struct {
    logic [5:0] op;
    logic       hit, dirty, ack;
    logic [6:0] flags;
    logic [1:0] sz;
    int         beat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic h, input logic d, input logic a);
    cur_op = op; cur_hit = h; cur_dirty = d; cur_ack = a;
    if0.opcode = op; if0.hit = h; if0.dirty = d; if0.mem_ack = a;
    if1.opcode = op; if1.hit = h; if1.dirty = d; if1.mem_ack = a;
  endtask

  function automatic obs_t sample(input int d);
    obs_t o;
    if (d == 0) begin
      o.flags = {if0.stall, if0.reg_write_enable, if0.cache_we, if0.cache_in_select,
                 if0.mem_req, if0.mem_we, if0.mem_in_select};
      o.sz = int'(if0.size); o.beat = int'(if0.beat_idx);
      o.hcnt = int'(if0.hit_count); o.mcnt = int'(if0.miss_count);
    end else begin
      o.flags = {if1.stall, if1.reg_write_enable, if1.cache_we, if1.cache_in_select,
                 if1.mem_req, if1.mem_we, if1.mem_in_select};
      o.sz = int'(if1.size); o.beat = int'(if1.beat_idx);
      o.hcnt = int'(if1.hit_count); o.mcnt = int'(if1.miss_count);
    end
    return o;
  endfunction

  function automatic bit op_load(input logic [5:0] op);
    return op == LW || op == LH || op == LB;
  endfunction
  function automatic bit op_store(input logic [5:0] op);
    return op == SW || op == SH || op == SB;
  endfunction
  function automatic int op_size(input logic [5:0] op);
    if (op == LH || op == SH) return 1;
    if (op == LB || op == SB) return 2;
    return 0;
  endfunction

  function automatic obs_t expect_of(input int d);
    obs_t e;
    bit ld = op_load(cur_op), st = op_store(cur_op);
    e.flags = 7'b0;
    if (rst_b) begin
      if (wb_left[d] > 0)        e.flags = 7'b1000111;
      else if (fill_left[d] > 0) e.flags = {1'b1, 1'b0, cur_ack, 1'b0, 1'b1, 1'b0, 1'b0};
      else if (ld || st) begin
        if (cur_hit) e.flags = {1'b0, ld, st, st, 3'b000};
        else         e.flags = 7'b1000000;
      end
    end
    e.sz   = op_size(cur_op);
    e.beat = (wb_left[d] > 0) ? lw[d] - wb_left[d] :
             (fill_left[d] > 0) ? lw[d] - fill_left[d] : 0;
    e.hcnt = hc[d];
    e.mcnt = mc[d];
    return e;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      wb_left[d] = 0; fill_left[d] = 0; hc[d] = 0; mc[d] = 0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (wb_left[d] > 0) begin
        if (cur_ack) begin
          wb_left[d]--;
          if (wb_left[d] == 0) fill_left[d] = lw[d];
        end
      end else if (fill_left[d] > 0) begin
        if (cur_ack) fill_left[d]--;
      end else if (op_load(cur_op) || op_store(cur_op)) begin
        if (cur_hit) hc[d] = (hc[d] < cmax[d]) ? hc[d] + 1 : hc[d];
        else begin
          mc[d] = (mc[d] < cmax[d]) ? mc[d] + 1 : mc[d];
          if (cur_dirty) wb_left[d] = lw[d];
          else           fill_left[d] = lw[d];
        end
      end
    end
  endtask

  // Called at the negative edge: model checks, then the clock edge, then settle.
  task automatic finish_cycle();
    obs_t a, e;
    if (!rst_b) model_reset();
    for (int d = 0; d < 2; d++) begin
      a = sample(d);
      e = expect_of(d);
      chk($sformatf("d%0d_flags", d), int'(a.flags), int'(e.flags));
      chk($sformatf("d%0d_size", d), a.sz, e.sz);
      chk($sformatf("d%0d_beat", d), a.beat, e.beat);
      chk($sformatf("d%0d_hit_count", d), a.hcnt, e.hcnt);
      chk($sformatf("d%0d_miss_count", d), a.mcnt, e.mcnt);
    end
    @(posedge clk);
    if (rst_b) model_edge();
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    finish_cycle();
  endtask

  vec_t vecs[23];
  logic [5:0] mem_ops[6] = '{LW, LH, LB, SW, SH, SB};

  initial begin
    vecs[0]  = '{LW,  1'b1, 1'b0, 1'b0, 7'b0100000, 2'b00, 0};
    vecs[1]  = '{SB,  1'b1, 1'b0, 1'b0, 7'b0011000, 2'b10, 0};
    vecs[2]  = '{NOP, 1'b1, 1'b1, 1'b1, 7'b0000000, 2'b00, 0};
    vecs[3]  = '{LW,  1'b0, 1'b0, 1'b1, 7'b1000000, 2'b00, 0};
    vecs[4]  = '{LW,  1'b0, 1'b0, 1'b0, 7'b1000100, 2'b00, 0};
    vecs[5]  = '{LW,  1'b0, 1'b0, 1'b1, 7'b1010100, 2'b00, 0};
    vecs[6]  = '{LW,  1'b0, 1'b0, 1'b0, 7'b1000100, 2'b00, 1};
    vecs[7]  = '{LW,  1'b0, 1'b0, 1'b1, 7'b1010100, 2'b00, 1};
    vecs[8]  = '{LW,  1'b0, 1'b0, 1'b0, 7'b1000100, 2'b00, 2};
    vecs[9]  = '{LW,  1'b0, 1'b0, 1'b1, 7'b1010100, 2'b00, 2};
    vecs[10] = '{LW,  1'b0, 1'b0, 1'b0, 7'b1000100, 2'b00, 3};
    vecs[11] = '{LW,  1'b0, 1'b0, 1'b1, 7'b1010100, 2'b00, 3};
    vecs[12] = '{LW,  1'b1, 1'b0, 1'b0, 7'b0100000, 2'b00, 0};
    vecs[13] = '{SW,  1'b0, 1'b1, 1'b1, 7'b1000000, 2'b00, 0};
    vecs[14] = '{SW,  1'b0, 1'b1, 1'b1, 7'b1000111, 2'b00, 0};
    vecs[15] = '{NOP, 1'b1, 1'b0, 1'b1, 7'b1000111, 2'b00, 1};
    vecs[16] = '{NOP, 1'b1, 1'b0, 1'b1, 7'b1000111, 2'b00, 2};
    vecs[17] = '{SW,  1'b0, 1'b1, 1'b1, 7'b1000111, 2'b00, 3};
    vecs[18] = '{SW,  1'b0, 1'b1, 1'b1, 7'b1010100, 2'b00, 0};
    vecs[19] = '{SW,  1'b0, 1'b1, 1'b1, 7'b1010100, 2'b00, 1};
    vecs[20] = '{SW,  1'b0, 1'b1, 1'b1, 7'b1010100, 2'b00, 2};
    vecs[21] = '{SW,  1'b0, 1'b1, 1'b1, 7'b1010100, 2'b00, 3};
    vecs[22] = '{SW,  1'b1, 1'b0, 1'b0, 7'b0011000, 2'b00, 0};

    model_reset();
    drive(LW, 1'b1, 1'b1, 1'b1);
    rst_b = 1'b0;
    cycle();
    cycle();
    rst_b = 1'b1;

    for (int i = 0; i < 23; i++) begin
      obs_t a;
      drive(vecs[i].op, vecs[i].hit, vecs[i].dirty, vecs[i].ack);
      @(negedge clk);
      a = sample(0);
      chk($sformatf("vec%0d_flags", i), int'(a.flags), int'(vecs[i].flags));
      chk($sformatf("vec%0d_size", i), a.sz, int'(vecs[i].sz));
      chk($sformatf("vec%0d_beat", i), a.beat, vecs[i].beat);
      finish_cycle();
    end
    chk("table_hit_count", int'(if0.hit_count), 4);
    chk("table_miss_count", int'(if0.miss_count), 2);

    // Reset during the second write-back beat.
    drive(SW, 1'b0, 1'b1, 1'b0);
    cycle();
    drive(SW, 1'b0, 1'b1, 1'b1);
    cycle();
    drive(SW, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("wb2_mem_req", int'(if0.mem_req), 1);
    chk("wb2_beat", int'(if0.beat_idx), 1);
    #2 rst_b = 1'b0;
    #1;
    chk("rst_mem_req", int'(if0.mem_req), 0);
    chk("rst_stall", int'(if0.stall), 0);
    chk("rst_beat", int'(if0.beat_idx), 0);
    chk("rst_hit_count", int'(if0.hit_count), 0);
    chk("rst_miss_count", int'(if0.miss_count), 0);
    finish_cycle();
    rst_b = 1'b1;
    drive(NOP, 1'b0, 1'b0, 1'b1);
    cycle();
    chk("post_rst_mem_req", int'(if0.mem_req), 0);

    // Hit counter saturation on the 2-bit instance.
    drive(LH, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle();
    chk("sat_hit_count_d1", int'(if1.hit_count), 3);
    chk("sat_hit_count_d0", int'(if0.hit_count), 5);
    cycle();
    chk("sat_hold_d1", int'(if1.hit_count), 3);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      int r = $urandom_range(0, 7);
      logic [5:0] op = (r < 6) ? mem_ops[r] : 6'($urandom);
      drive(op, 1'($urandom), 1'($urandom), 1'($urandom));
      rst_b = ($urandom_range(0, 299) != 0);
      cycle();
    end
    rst_b = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cache_ctrl_fsm.md
Name: cache_ctrl_fsm

Overview:
- Next-generation data-cache control unit for the MIPS-style pipeline; replaces the fixed-latency counter controller.
- Drives the cache/memory datapath selects for LW/LH/LB/SW/SH/SB.
- Performs multi-beat write-back and line fill through a req/ack memory handshake.
- Line length and statistics-counter width are parameters; stalls the pipeline while a miss is serviced and keeps saturating hit/miss counters.

Parameters:
- LINE_WORDS, 4: words per cache line (beats per write-back or fill), >=1.
- BEAT_W, 2: width of beat_idx, >= max(1, clog2(LINE_WORDS)).
- CNT_W, 16: width of the hit_count and miss_count statistics counters.

Ports:
- clk  in  1  clock
- rst_b  in  1  reset, asynchronous, active-low
- opcode  in  6  current MEM-stage opcode
- hit  in  1  tag match and valid for the current address
- dirty  in  1  victim line dirty
- mem_ack  in  1  memory accepted or returned the current beat
- stall  out  1  freeze pipeline
- reg_write_enable  out  1  load result write-back enable
- cache_we  out  1  cache word write
- cache_in_select  out  1  1 = cache data from CPU store, 0 = from memory
- mem_req  out  1  memory beat request
- mem_we  out  1  memory write (write-back beat)
- mem_in_select  out  1  1 = memory address/data from victim line
- size  out  2  00 word, 01 half, 10 byte
- beat_idx  out  BEAT_W  word index within the line for the current beat
- hit_count  out  CNT_W  saturating count of hit accesses
- miss_count  out  CNT_W  saturating count of misses

Behaviour:
- Opcodes: LW 100011, LH 100001, LB 100000, SW 101011, SH 101001, SB 101000. Any other opcode is non-memory.
- size: word, half or byte per opcode; 00 for non-memory ops.
- Reset: state IDLE; beat_idx, hit_count, miss_count = 0. All 1-bit outputs are 0 while rst_b is low.
- Outputs are combinational from state, opcode and inputs. Every output not asserted by a rule below is 0.

State IDLE:
- Non-memory opcode: all outputs 0.
- Memory op with hit=1:
  - Loads: reg_write_enable=1.
  - Stores: cache_we=1 and cache_in_select=1.
  - stall=0; zero-latency hit.
  - hit_count increments at the clock edge.
- Memory op with hit=0:
  - stall=1; miss_count increments; beat_idx is cleared to 0.
  - dirty=1 -> WB; dirty=0 -> FILL.

State WB:
- stall=1, mem_req=1, mem_we=1, mem_in_select=1.
- On mem_ack, beat_idx increments.
- On mem_ack with beat_idx==LINE_WORDS-1: beat_idx clears to 0 and the next state is FILL.

State FILL:
- stall=1, mem_req=1, mem_we=0.
- cache_we=mem_ack and cache_in_select=0, so each acked beat writes word beat_idx.
- On mem_ack, beat_idx increments.
- On mem_ack with beat_idx==LINE_WORDS-1: beat_idx clears to 0 and the next state is IDLE.

Replay after fill:
- On returning to IDLE, hit is re-evaluated, is now 1, and the access completes as a hit in that cycle.
- That hit is also counted in hit_count, so one missed access counts as one miss and one hit.

Boundary conditions:
- mem_ack in IDLE is ignored.
- Without mem_ack, WB and FILL hold state and outputs indefinitely.
- opcode, hit and dirty are ignored while in WB and FILL; the pipeline is frozen so they are stable.
- LINE_WORDS=1: WB and FILL each last exactly one acked beat.
- hit_count and miss_count saturate at 2^CNT_W-1 and do not wrap.
- rst_b asserted mid-WB or mid-FILL aborts to IDLE immediately, with no further mem_req.

Test Plan:
- Reset, then LW with hit=1 -> reg_write_enable=1, stall=0, size=00 in the same cycle; hit_count=1 after the edge.
- SB with hit=1 -> cache_we=1, cache_in_select=1, size=10, stall=0.
- LW, hit=0, dirty=0, mem_ack on every 2nd cycle, LINE_WORDS=4 -> FILL with 4 cache_we pulses at beat_idx 0,1,2,3 and stall held; then IDLE hit with reg_write_enable=1; miss_count=1, hit_count=1.
- SW, hit=0, dirty=1, mem_ack always 1 -> 4 cycles mem_we=1/mem_in_select=1 (beat_idx 0..3), then 4 fill cycles, then store hit with cache_we=1, cache_in_select=1.
- Reset pulse during the 2nd WB beat -> mem_req=0 immediately, state IDLE, counters 0, beat_idx 0.
- CNT_W=2, 5 hits -> hit_count reaches 3 and stays at 3.
